// File: rtl/wb_check_monitor.sv
// Writeback scoreboard: compares the WB-stage stream against a programmable
// table of (instruction, data, register) entries and reports a run verdict.
module wb_check_monitor #(
  parameter int WORD      = 64,
  parameter int INST_SIZE = 32,
  parameter int DEPTH     = 16,
  parameter int ORDERED   = 1,
  parameter int TIMEOUT   = 4096,
  parameter int CNT_W     = 8,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [INST_SIZE-1:0] cfg_inst,
  input  logic [WORD-1:0]      cfg_data,
  input  logic [4:0]           cfg_reg,
  input  logic [IDX_W:0]       cfg_num,
  input  logic                 start,
  input  logic                 mon_valid,
  input  logic [INST_SIZE-1:0] mon_inst,
  input  logic [WORD-1:0]      mon_w_data,
  input  logic [4:0]           mon_w_reg,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [WORD-1:0]      rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [IDX_W-1:0]     first_fail_idx
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q;
  logic [INST_SIZE-1:0] tag_q [DEPTH];
  logic [WORD-1:0]      exp_q [DEPTH];
  logic [4:0]           reg_q [DEPTH];
  logic [WORD-1:0]      cap_q [DEPTH];
  logic [IDX_W:0]       num_q, ptr_q, chk_q;
  logic [DEPTH-1:0]     map_q;
  logic [TW-1:0]        timer_q;
  logic [CNT_W-1:0]     pass_cnt_q, fail_cnt_q;
  logic [IDX_W-1:0]     ffail_q;
  logic                 timeout_q;
  logic [WORD-1:0]      rd_data_q;

  logic                 hit_d, ok_d, tmo_d;
  logic [IDX_W-1:0]     hit_idx_d;
  logic [IDX_W:0]       chk_d;

  // At most one entry is selected per cycle; in any-order mode the loop runs
  // high-to-low so the lowest matching unmatched index wins.
  always_comb begin
    hit_d     = 1'b0;
    hit_idx_d = '0;
    if (state_q == S_RUN && mon_valid) begin
      if (ORDERED != 0) begin
        hit_idx_d = ptr_q[IDX_W-1:0];
        hit_d     = (ptr_q < num_q) && (tag_q[hit_idx_d] == mon_inst);
      end else begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (!map_q[i] && ((IDX_W+1)'(i) < num_q) && (tag_q[i] == mon_inst)) begin
            hit_d     = 1'b1;
            hit_idx_d = IDX_W'(i);
          end
        end
      end
    end
    ok_d  = (mon_w_data == exp_q[hit_idx_d]) && (mon_w_reg == reg_q[hit_idx_d]);
    chk_d = chk_q + (IDX_W+1)'(hit_d);
    tmo_d = (timer_q == TW'(TIMEOUT - 1));
  end

  // Table and capture storage carry no reset so a table survives rst.
  always_ff @(posedge clk) begin
    if (!rst && cfg_we && state_q == S_IDLE) begin
      tag_q[cfg_idx] <= cfg_inst;
      exp_q[cfg_idx] <= cfg_data;
      reg_q[cfg_idx] <= cfg_reg;
    end
    if (!rst && hit_d) cap_q[hit_idx_d] <= mon_w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      ptr_q      <= '0;
      chk_q      <= '0;
      map_q      <= '0;
      timer_q    <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      ffail_q    <= '0;
      timeout_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_data_q <= cap_q[rd_idx];
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_RUN;
            num_q      <= cfg_num;
            ptr_q      <= '0;
            chk_q      <= '0;
            map_q      <= '0;
            timer_q    <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            ffail_q    <= '0;
            timeout_q  <= 1'b0;
          end
        end
        S_RUN: begin
          timer_q <= timer_q + TW'(1);
          if (hit_d) begin
            map_q[hit_idx_d] <= 1'b1;
            ptr_q            <= ptr_q + (IDX_W+1)'(1);
            chk_q            <= chk_d;
            if (ok_d) begin
              if (pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
            end else begin
              if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
              if (fail_cnt_q == '0) ffail_q <= hit_idx_d;
            end
          end
          // Completion takes priority over the timer in the same cycle.
          if (chk_d >= num_q) begin
            state_q <= S_DONE;
          end else if (tmo_d) begin
            state_q   <= S_DONE;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_data        = rd_data_q;
  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (fail_cnt_q == '0) && !timeout_q;
  assign timeout        = timeout_q;
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = ffail_q;
endmodule

// File: doc/wb_check_monitor.md
Name: wb_check_monitor

Overview:
- Parametrised writeback scoreboard for the LEGv8 datapath.
- Holds a programmable table of (instruction, expected write data, expected destination register) entries and watches the WB-stage writeback stream.
- Reports per-entry pass/fail, captured values, pass/fail counts, a done/timeout flag and an overall verdict.
- Replaces per-program hard-coded checks in test benches; can also be instantiated beside TOP as an on-chip self-check.

Parameters:
- WORD, 64, writeback data width.
- INST_SIZE, 32, instruction width.
- DEPTH, 16, number of table entries (power of 2, 2..64); IDX_W = clog2(DEPTH).
- ORDERED, 1, 1 = entries must be hit in table order; 0 = any order.
- TIMEOUT, 4096, max RUN cycles before forced DONE (>= 1).
- CNT_W, 8, width of pass/fail counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  table write strobe (accepted in IDLE only).
- cfg_idx  in  IDX_W  table entry written.
- cfg_inst  in  INST_SIZE  instruction tag for the entry.
- cfg_data  in  WORD  expected write-back data.
- cfg_reg  in  5  expected destination register.
- cfg_num  in  IDX_W+1  number of active entries (0..DEPTH), latched on start.
- start  in  1  begin a check run (accepted in IDLE or DONE).
- mon_valid  in  1  a writeback observation is present this cycle.
- mon_inst  in  INST_SIZE  instruction associated with the writeback.
- mon_w_data  in  WORD  writeback data.
- mon_w_reg  in  5  writeback destination register.
- rd_idx  in  IDX_W  captured-value read index.
- rd_data  out  WORD  captured data for rd_idx, registered, 1-cycle latency.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.
- pass  out  1  done && fail_cnt == 0 && !timeout.
- timeout  out  1  run ended by timer.
- pass_cnt  out  CNT_W  entries matched with correct data and register.
- fail_cnt  out  CNT_W  entries matched with wrong data or register.
- first_fail_idx  out  IDX_W  index of the first failing entry; valid when fail_cnt != 0.

Behaviour:
- Reset:
  - state = IDLE.
  - busy, done, pass, timeout, pass_cnt, fail_cnt, first_fail_idx, rd_data = 0.
  - Match bitmap, entry pointer and timer = 0.
  - Table and capture RAM contents are not reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - cfg_we writes the entry at the edge.
  - start -> RUN; latches cfg_num; clears counters, bitmap, pointer, timer, timeout, first_fail_idx.
  - cfg_we and start in the same cycle: the write lands and is part of the run.
- RUN:
  - Timer increments every cycle.
  - On mon_valid, the observation is compared combinationally.
  - ORDERED=1: compare only entry[ptr]. If mon_inst equals the tag, the entry is checked and ptr increments. Other instructions are ignored.
  - ORDERED=0: compare all unmatched entries below cfg_num. The lowest index with an equal tag is checked. Entries already matched ignore later occurrences.
  - A checked entry passes if mon_w_data == data and mon_w_reg == reg; otherwise it fails.
  - On the check edge:
    - mon_w_data is written to the capture RAM at the entry index.
    - The bitmap bit is set.
    - pass_cnt or fail_cnt increments, saturating at 2^CNT_W-1.
    - On the first fail, first_fail_idx is set to the entry index.
  - At most one entry is checked per cycle.
  - When the checked count reaches cfg_num, the state becomes DONE at the same edge as the final check.
  - Timer reaching TIMEOUT-1 without completion -> DONE with timeout = 1.
  - Final check and timeout in the same cycle: the check wins and timeout stays 0.
  - cfg_num == 0: RUN lasts exactly one cycle, then DONE with pass = 1.
  - cfg_we in RUN is ignored.
  - start in RUN is ignored.
- DONE:
  - All status outputs hold.
  - mon_valid is ignored.
  - start -> RUN as from IDLE.
  - cfg_we is ignored.
- rst asserted mid-RUN: IDLE on the next edge; counters cleared; table retained, so a new start re-runs the same table.
- rd_data is readable in any state.

Test Plan:
- Bubble-sort load table, ORDERED=1, cfg_num=9. Tags 'hf8400009, 'hf8408009 … 'hf8440009, data 1,2,'h16,'h27,'h45,'h99,'h107,'h253,'h800, reg 9, driven in order with noise instructions interleaved -> done=1, pass=1, pass_cnt=9, fail_cnt=0, rd_data(idx 8)='h800.
- Same table with entry 3 observed as 'h28 -> fail_cnt=1, first_fail_idx=3, pass=0, rd_data(3)='h28.
- Same table with mon_w_reg=10 on entry 0 -> fail_cnt=1, first_fail_idx=0.
- ORDERED=0, 4 entries driven in order 3,1,0,2, with entry 1's tag repeated later carrying wrong data -> pass_cnt=4, fail_cnt=0, repeat ignored.
- Timeout case, TIMEOUT=32, cfg_num=2, only one match driven -> done at the 32nd RUN cycle, timeout=1, pass=0, pass_cnt=1.
- Boundaries:
  - cfg_num=0 -> done one cycle after start, pass=1.
  - rst asserted mid-RUN -> IDLE, counters 0.
  - start again with the table retained -> full pass.
